// File: rtl/vec_sca_regfile.sv
// Vector (16 x 128b) and scalar (16 x 32b) register banks fed by the WB stage, with two read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining VRF_BYPASS_EN.
module vec_sca_regfile #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int VW   = 128,
  parameter int SW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wreg3,
  input  logic [VW-1:0] ResRV2,
  input  logic [AW-1:0] R_V_dest3,
  input  logic          VF3,
  input  logic [AW-1:0] ra1,
  input  logic          rvf1,
  output logic [VW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  input  logic          rvf2,
  output logic [VW-1:0] rd2
);

  logic [VW-1:0] vreg [NREG];
  logic [SW-1:0] sreg [NREG];

  // Scalar entry 0 is only ever cleared; the read mux also forces it to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        vreg[i] <= '0;
        sreg[i] <= '0;
      end
    end else if (wreg3) begin
      if (VF3)
        vreg[R_V_dest3] <= ResRV2;
      else if (R_V_dest3 != '0)
        sreg[R_V_dest3] <= ResRV2[SW-1:0];
    end
  end

  function automatic logic [VW-1:0] read_port(input logic [AW-1:0] ra, input logic rvf);
    logic [VW-1:0] r;
    r = '0;
    if (rvf)
      r = vreg[ra];
    else if (ra != '0)
      r = {{(VW-SW){1'b0}}, sreg[ra]};
`ifdef VRF_BYPASS_EN
    // Forwarding is suppressed while reset holds the banks cleared.
    if (!rst && wreg3 && (VF3 == rvf) && (R_V_dest3 == ra)) begin
      if (rvf)
        r = ResRV2;
      else if (ra != '0)
        r = {{(VW-SW){1'b0}}, ResRV2[SW-1:0]};
    end
`endif
    return r;
  endfunction

  always_comb begin
    rd1 = '0;
    rd1 = read_port(ra1, rvf1);
  end

  always_comb begin
    rd2 = '0;
    rd2 = read_port(ra2, rvf2);
  end

endmodule

// File: tb/tb_vec_sca_regfile.sv
// Scoreboard bench for vec_sca_regfile: a driver pushes expected read data from an array model,
// a negedge monitor pops and compares. Build with or without VRF_BYPASS_EN.
module tb_vec_sca_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wreg3 = 1'b0;
  logic [127:0] ResRV2 = '0;
  logic [3:0]   R_V_dest3 = '0;
  logic         VF3 = 1'b0;
  logic [3:0]   ra1 = '0;
  logic         rvf1 = 1'b0;
  logic [127:0] rd1;
  logic [3:0]   ra2 = '0;
  logic         rvf2 = 1'b0;
  logic [127:0] rd2;

  vec_sca_regfile dut (
    .clk(clk), .rst(rst), .wreg3(wreg3), .ResRV2(ResRV2), .R_V_dest3(R_V_dest3), .VF3(VF3),
    .ra1(ra1), .rvf1(rvf1), .rd1(rd1), .ra2(ra2), .rvf2(rvf2), .rd2(rd2)
  );

  always #5 clk = ~clk;

  // architectural model
  logic [127:0] mv [16];
  logic [31:0]  ms [16];

  logic [127:0] q_e1 [$];
  logic [127:0] q_e2 [$];
  string        q_tag [$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [127:0] exp_rd(input logic [3:0] ra, input logic rvf);
    if (rvf) return mv[ra];
    if (ra == 4'd0) return '0;
    return {96'h0, ms[ra]};
  endfunction

`ifdef VRF_BYPASS_EN
  function automatic logic [127:0] fwd(input logic [3:0] ra, input logic rvf, input logic [127:0] d);
    if (rvf) return d;
    if (ra == 4'd0) return '0;
    return {96'h0, d[31:0]};
  endfunction
`endif

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // rmode: 0 = no reset, 1 = reset held across the next edge, 2 = reset pulse inside this cycle
  task automatic step(input int rmode, input logic we, input logic vf, input logic [3:0] dst,
                      input logic [127:0] d, input logic [3:0] a1, input logic f1,
                      input logic [3:0] a2, input logic f2, input string tag);
    logic [127:0] e1, e2;
    @(posedge clk); #1;
    rst = (rmode != 0);
    wreg3 = we; VF3 = vf; R_V_dest3 = dst; ResRV2 = d;
    ra1 = a1; rvf1 = f1; ra2 = a2; rvf2 = f2;
    if (rmode != 0)
      for (int i = 0; i < 16; i++) begin mv[i] = '0; ms[i] = '0; end
    if (rmode != 0) begin
      e1 = '0; e2 = '0;
    end else begin
      e1 = exp_rd(a1, f1);
      e2 = exp_rd(a2, f2);
`ifdef VRF_BYPASS_EN
      if (we && vf == f1 && dst == a1) e1 = fwd(a1, f1, d);
      if (we && vf == f2 && dst == a2) e2 = fwd(a2, f2, d);
`endif
    end
    q_e1.push_back(e1); q_e2.push_back(e2); q_tag.push_back(tag);
    if (rmode != 1 && we) begin
      if (vf) mv[dst] = d;
      else if (dst != 4'd0) ms[dst] = d[31:0];
    end
    if (rmode == 2) begin
      #6 rst = 1'b0;
    end
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 16; i++)
      step(0, 1'b0, 1'b0, 4'd0, '0, 4'(i), 1'b1, 4'(i), 1'b0, tag);
  endtask

  task automatic rand_step(input logic we, input string tag);
    step(0, we, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd128(),
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), tag);
  endtask

  always @(negedge clk) begin
    if (q_e1.size() > 0) begin
      logic [127:0] e1, e2;
      string tag;
      e1 = q_e1.pop_front(); e2 = q_e2.pop_front(); tag = q_tag.pop_front();
      n_tests++;
      if (rd1 !== e1) begin
        n_fail++;
        $display("FAIL %s rd1: got %h expected %h", tag, rd1, e1);
      end
      n_tests++;
      if (rd2 !== e2) begin
        n_fail++;
        $display("FAIL %s rd2: got %h expected %h", tag, rd2, e2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mv[i] = '0; ms[i] = '0; end

    // reset for two cycles, then all indices of both banks read zero
    for (int i = 0; i < 16; i++)
      step((i < 2) ? 1 : 0, 1'b0, 1'b0, 4'd0, '0, 4'(i), 1'b1, 4'(i), 1'b0, "reset");

    // vector write / read; same index on the scalar bank stays zero
    step(0, 1'b1, 1'b1, 4'd3, 128'hFFFF_0001_FFFF_0002_FFFF_0003_0000_0008,
         4'd3, 1'b1, 4'd3, 1'b0, "vec_wr");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd3, 1'b1, 4'd3, 1'b0, "vec_rd");

    // scalar truncation and the hardwired zero register
    step(0, 1'b1, 1'b0, 4'd7, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_1234_5678,
         4'd7, 1'b0, 4'd7, 1'b1, "sca_wr");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd7, 1'b0, 4'd7, 1'b0, "sca_trunc");
    step(0, 1'b1, 1'b0, 4'd0, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF,
         4'd0, 1'b0, 4'd0, 1'b1, "sreg0_wr");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b0, 4'd0, 1'b0, "sreg0_rd");

    // bypass: vector hit, then bank mismatch must not hit
    step(0, 1'b1, 1'b1, 4'd9, 128'h1, 4'd9, 1'b1, 4'd9, 1'b0, "byp_vec");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd9, 1'b1, 4'd9, 1'b0, "byp_vec_after");
    step(0, 1'b1, 1'b0, 4'd9, 128'h5555, 4'd9, 1'b0, 4'd9, 1'b0, "sca9_wr");
    step(0, 1'b1, 1'b1, 4'd9, 128'h2, 4'd9, 1'b0, 4'd9, 1'b1, "byp_mismatch");
    step(0, 1'b1, 1'b0, 4'd5, 128'h77, 4'd5, 1'b1, 4'd5, 1'b0, "byp_sca");

    // random writes and reads
    for (int i = 0; i < 200; i++) rand_step(1'($urandom_range(0, 1)), "random");
    readback("rand_readback");

    // write-disable with random data
    for (int i = 0; i < 100; i++) rand_step(1'b0, "wr_disable");
    readback("wd_readback");

    // async reset pulse mid-stream; the write of the pulsed cycle commits after release
    for (int i = 0; i < 20; i++) rand_step(1'b1, "pre_reset");
    step(2, 1'b1, 1'b1, 4'd12, 128'hCAFE_F00D, 4'd12, 1'b1, 4'd4, 1'b1, "rst_pulse");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd12, 1'b1, 4'd4, 1'b1, "post_rst_wr");
    readback("post_rst_readback");

    // reset held across a write edge: the write is lost
    for (int i = 0; i < 10; i++) rand_step(1'b1, "pre_reset2");
    step(1, 1'b1, 1'b0, 4'd6, 128'h1234, 4'd6, 1'b0, 4'd2, 1'b1, "rst_held_wr");
    step(0, 1'b0, 1'b0, 4'd0, '0, 4'd6, 1'b0, 4'd2, 1'b1, "rst_wins");

    for (int i = 0; i < 4 && q_e1.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (q_e1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q_e1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
